// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - shared CHIP-8 types, constants and the LFSR step function
package chip8_pkg;

    // Random unit FSM states
    typedef enum logic [1:0] {
        RND_IDLE = 2'd0,
        RND_STIR = 2'd1,
        RND_DONE = 2'd2
    } rnd_state_e;

    localparam logic [7:0] LFSR_SEED = 8'hFF;
    // Taps 8,6,5,4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // One left shift with XOR feedback into bit 0. An all-zero register
    // would lock up forever, so it is forced back to the seed.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        logic [7:0] n;
        if (s == 8'h00) begin
            n = LFSR_SEED;
        end else begin
            n = {s[6:0], ^(s & LFSR_TAPS)};
        end
        return n;
    endfunction

endpackage

// File: rtl/chip8_rnd_unit.sv
// rtl/chip8_rnd_unit.sv - CXNN random-byte service: stirred LFSR, masked result
//
// Ports:
//   clk        system clock, all logic on posedge
//   reset      synchronous active-high reset
//   req        request, sampled only while idle
//   mask       NN byte, latched together with an accepted req
//   busy       high while stirring and in the done cycle
//   done       one-cycle completion pulse
//   value      registered masked random byte, held until the next result
//   lfsr_state current LFSR register (debug/verification)
module chip8_rnd_unit
    import chip8_pkg::*;
#(
    parameter logic [7:0] STIR_STEPS = 8'd8,  // 1..255
    parameter bit          FREE_RUN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req,
    input  logic [7:0] mask,
    output logic       busy,
    output logic       done,
    output logic [7:0] value,
    output logic [7:0] lfsr_state
);

    rnd_state_e state;
    logic [7:0] lfsr_q;
    logic [7:0] mask_q;
    logic [7:0] counter;
    logic [7:0] lfsr_step;

    assign lfsr_step = lfsr_next(lfsr_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RND_IDLE;
            lfsr_q  <= LFSR_SEED;
            mask_q  <= 8'h00;
            counter <= 8'h00;
            value   <= 8'h00;
        end else begin
            case (state)
                RND_IDLE: begin
                    if (FREE_RUN) begin
                        lfsr_q <= lfsr_step;
                    end
                    if (req) begin
                        mask_q  <= mask;
                        counter <= STIR_STEPS;
                        state   <= RND_STIR;
                    end
                end
                RND_STIR: begin
                    lfsr_q  <= lfsr_step;
                    counter <= counter - 8'd1;
                    // Last stir step: publish the freshly stepped value
                    if (counter == 8'd1) begin
                        value <= lfsr_step & mask_q;
                        state <= RND_DONE;
                    end
                end
                RND_DONE: begin
                    state <= RND_IDLE;
                end
                default: begin
                    state <= RND_IDLE;
                end
            endcase
        end
    end

    assign busy       = (state != RND_IDLE);
    assign done       = (state == RND_DONE);
    assign lfsr_state = lfsr_q;

endmodule

// File: tb/tb_chip8_rnd_unit.sv
// tb/tb_chip8_rnd_unit.sv - self-checking bench for chip8_rnd_unit
module tb_chip8_rnd_unit;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic       req8 = 1'b0, req1 = 1'b0, reqf = 1'b0;
    logic [7:0] mask8 = 8'h00, mask1 = 8'h00, maskf = 8'h00;
    logic       busy8, busy1, busyf;
    logic       done8, done1, donef;
    logic [7:0] value8, value1, valuef;
    logic [7:0] lfsr8, lfsr1, lfsrf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    chip8_rnd_unit #(.STIR_STEPS(8'd8), .FREE_RUN(1'b0)) u_dut8 (
        .clk(clk), .reset(reset), .req(req8), .mask(mask8),
        .busy(busy8), .done(done8), .value(value8), .lfsr_state(lfsr8)
    );

    chip8_rnd_unit #(.STIR_STEPS(8'd1), .FREE_RUN(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .req(req1), .mask(mask1),
        .busy(busy1), .done(done1), .value(value1), .lfsr_state(lfsr1)
    );

    chip8_rnd_unit #(.STIR_STEPS(8'd5), .FREE_RUN(1'b1)) u_dutf (
        .clk(clk), .reset(reset), .req(reqf), .mask(maskf),
        .busy(busyf), .done(donef), .value(valuef), .lfsr_state(lfsrf)
    );

    // Reference: feedback is the parity of bits 7,5,4,3, computed arithmetically
    function automatic int ref_step(input int s);
        int fb;
        if (s == 0) return 255;
        fb = ((s >> 7) + (s >> 5) + (s >> 4) + (s >> 3)) % 2;
        return ((s * 2) % 256) + fb;
    endfunction

    function automatic logic [7:0] ref_after(input int n);
        int s;
        s = 255;
        for (int i = 0; i < n; i++) s = ref_step(s);
        return s[7:0];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        req8 = 1'b0; req1 = 1'b0; reqf = 1'b0;
        tick;
        tick;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick;
        tick;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy8); end
        total++; if (done8 !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done8); end
        total++; if (lfsr8 !== 8'hFF) begin bad++; $display("FAIL reset_lfsr got=%h exp=ff", lfsr8); end
        total++; if (value8 !== 8'h00) begin bad++; $display("FAIL reset_value got=%h exp=00", value8); end
        total++; if (lfsrf !== 8'hFF) begin bad++; $display("FAIL reset_lfsr_free got=%h exp=ff", lfsrf); end
        reset = 1'b0;
    endtask

    task automatic test_single(input logic [7:0] m, input logic [7:0] exp_v);
        int pulses;
        int at;
        do_reset;
        mask8 = m;
        req8 = 1'b1;
        tick;
        req8 = 1'b0;
        pulses = 0;
        at = -1;
        for (int i = 1; i <= 20; i++) begin
            tick;
            if (done8) begin
                pulses++;
                if (at < 0) at = i;
                total++; if (value8 !== exp_v) begin bad++; $display("FAIL single_value mask=%h got=%h exp=%h", m, value8, exp_v); end
                total++; if (value8 !== (ref_after(8) & m)) begin bad++; $display("FAIL single_model mask=%h got=%h exp=%h", m, value8, ref_after(8) & m); end
                total++; if (lfsr8 !== 8'h0B) begin bad++; $display("FAIL single_lfsr got=%h exp=0b", lfsr8); end
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL single_pulses got=%0d exp=1", pulses); end
        total++; if (at != 8) begin bad++; $display("FAIL single_latency got=%0d exp=8", at); end
    endtask

    task automatic test_back_to_back;
        int n;
        do_reset;
        mask1 = 8'hFF;
        req1 = 1'b1;
        tick;
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            tick;
            if (done1) begin
                if (n == 0) begin
                    total++; if (i != 1) begin bad++; $display("FAIL b2b_first_at got=%0d exp=1", i); end
                    total++; if (value1 !== 8'hFE) begin bad++; $display("FAIL b2b_first_value got=%h exp=fe", value1); end
                end else if (n == 1) begin
                    total++; if (i != 4) begin bad++; $display("FAIL b2b_second_at got=%0d exp=4", i); end
                    total++; if (value1 !== 8'hFC) begin bad++; $display("FAIL b2b_second_value got=%h exp=fc", value1); end
                end
                n++;
            end
        end
        req1 = 1'b0;
        total++; if (n != 3) begin bad++; $display("FAIL b2b_pulses got=%0d exp=3", n); end
    endtask

    task automatic test_free_run;
        logic [7:0] exp_seq [3];
        exp_seq = '{8'hFE, 8'hFC, 8'hF8};
        reset = 1'b1;
        reqf = 1'b0;
        tick;
        total++; if (lfsrf !== 8'hFF) begin bad++; $display("FAIL free_start got=%h exp=ff", lfsrf); end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++; if (lfsrf !== exp_seq[i]) begin bad++; $display("FAIL free_step%0d got=%h exp=%h", i, lfsrf, exp_seq[i]); end
            total++; if (lfsrf !== ref_after(i + 1)) begin bad++; $display("FAIL free_model%0d got=%h exp=%h", i, lfsrf, ref_after(i + 1)); end
            total++; if ({busyf, donef} !== 2'b00) begin bad++; $display("FAIL free_idle_flags got=%b exp=00", {busyf, donef}); end
        end
    endtask

    task automatic test_ignore_req;
        int pulses;
        do_reset;
        mask8 = 8'hFF;
        req8 = 1'b1;
        tick;
        req8 = 1'b0;
        tick;
        tick;
        req8 = 1'b1;
        mask8 = 8'h0E;
        tick;
        req8 = 1'b0;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done8) begin
                pulses++;
                total++; if (value8 !== 8'h0B) begin bad++; $display("FAIL ignore_value got=%h exp=0b", value8); end
            end
        end
        total++; if (pulses != 1) begin bad++; $display("FAIL ignore_pulses got=%0d exp=1", pulses); end
    endtask

    task automatic test_reset_mid_stir;
        int pulses;
        int at;
        do_reset;
        mask8 = 8'hFF;
        req8 = 1'b1;
        tick;
        req8 = 1'b0;
        tick;
        tick;
        tick;
        reset = 1'b1;
        tick;
        reset = 1'b0;
        total++; if (busy8 !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy8); end
        total++; if (lfsr8 !== 8'hFF) begin bad++; $display("FAIL midrst_lfsr got=%h exp=ff", lfsr8); end
        total++; if (value8 !== 8'h00) begin bad++; $display("FAIL midrst_value got=%h exp=00", value8); end
        pulses = (done8 === 1'b1) ? 1 : 0;
        for (int i = 0; i < 12; i++) begin
            tick;
            if (done8) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL midrst_pulses got=%0d exp=0", pulses); end
        req8 = 1'b1;
        tick;
        req8 = 1'b0;
        at = -1;
        for (int i = 1; i <= 12 && at < 0; i++) begin
            tick;
            if (done8) at = i;
        end
        total++; if (at != 8) begin bad++; $display("FAIL midrst_latency got=%0d exp=8", at); end
        total++; if (value8 !== 8'h0B) begin bad++; $display("FAIL midrst_value_after got=%h exp=0b", value8); end
    endtask

    task automatic test_random_held;
        int n;
        int at;
        logic [7:0] m;
        do_reset;
        n = 0;
        for (int it = 0; it < 6; it++) begin
            m = 8'($urandom);
            repeat ($urandom_range(0, 3)) tick;
            mask8 = m;
            req8 = 1'b1;
            tick;
            req8 = 1'b0;
            mask8 = 8'($urandom);
            n += 8;
            at = -1;
            for (int i = 1; i <= 12 && at < 0; i++) begin
                tick;
                if (done8) at = i;
            end
            total++; if (at != 8) begin bad++; $display("FAIL rnd_latency it=%0d got=%0d exp=8", it, at); end
            total++; if (value8 !== (ref_after(n) & m)) begin bad++; $display("FAIL rnd_value it=%0d got=%h exp=%h", it, value8, ref_after(n) & m); end
            total++; if (lfsr8 !== ref_after(n)) begin bad++; $display("FAIL rnd_lfsr it=%0d got=%h exp=%h", it, lfsr8, ref_after(n)); end
            tick;
            total++; if (value8 !== (ref_after(n) & m)) begin bad++; $display("FAIL rnd_value_hold it=%0d got=%h exp=%h", it, value8, ref_after(n) & m); end
        end
    endtask

    task automatic test_random_free;
        int k;
        int at;
        logic [7:0] m;
        for (int it = 0; it < 4; it++) begin
            do_reset;
            k = $urandom_range(0, 5);
            m = 8'($urandom);
            repeat (k) tick;
            maskf = m;
            reqf = 1'b1;
            tick;
            reqf = 1'b0;
            at = -1;
            for (int i = 1; i <= 10 && at < 0; i++) begin
                tick;
                if (donef) at = i;
            end
            total++; if (at != 5) begin bad++; $display("FAIL free_req_latency it=%0d got=%0d exp=5", it, at); end
            total++; if (valuef !== (ref_after(k + 6) & m)) begin bad++; $display("FAIL free_req_value it=%0d got=%h exp=%h", it, valuef, ref_after(k + 6) & m); end
            total++; if (lfsrf !== ref_after(k + 6)) begin bad++; $display("FAIL free_req_lfsr it=%0d got=%h exp=%h", it, lfsrf, ref_after(k + 6)); end
        end
    endtask

    initial begin
        test_reset;
        test_single(8'hFF, 8'h0B);
        test_single(8'h0E, 8'h0A);
        test_single(8'hF0, 8'h00);
        test_back_to_back;
        test_free_run;
        test_ignore_req;
        test_reset_mid_stir;
        test_random_held;
        test_random_free;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
